// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// instruction-fetch port and the data port. Data normally wins; a
// starvation counter hands the port to IF after STARVE_LIMIT data grants
// made while a fetch was waiting.
// Optional build macro ARB_TIMEOUT_EN adds a BUSY watchdog that aborts an
// access after TIMEOUT_CYCLES cycles without Mem_Ack and sets a sticky Bus_Err.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  output logic        IF_Ready,
  output logic [31:0] IF_Rdata,
  input  logic        MEM_Read,
  input  logic        MEM_Write,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_Wdata,
  output logic        MEM_Ready,
  output logic [31:0] MEM_Rdata,
  output logic        Stall_IF,
  output logic        Stall_MEM,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_Wdata,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_Rdata,
  output logic        Bus_Err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Reject nonsensical configurations at elaboration time.
  if (STARVE_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("mem_port_arbiter: STARVE_LIMIT and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   starve_cnt;
  logic            data_req, busy, done, timeout;
  logic            grant_d, grant_if;

  assign data_req  = MEM_Read | MEM_Write;
  assign busy      = (state != IDLE);
  assign done      = busy & (Mem_Ack | timeout);

  assign Stall_IF  = IF_Req & ~IF_Ready;
  assign Stall_MEM = data_req & ~MEM_Ready;

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wdog;
  logic          bus_err_q;

  // Ack on the last allowed cycle still wins over the timeout.
  assign timeout = busy & ~Mem_Ack & (wdog == WW'(TIMEOUT_CYCLES - 1));
  assign Bus_Err = bus_err_q;

  // Watchdog: counts BUSY cycles of the current access; sticky error on expiry.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wdog      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (grant_d | grant_if) wdog <= '0;
      else if (busy && !done) wdog <= wdog + 1'b1;
      if (timeout) bus_err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign Bus_Err = 1'b0;
`endif

  // Next state and grant decision; arbitration only happens in IDLE,
  // which includes the Ready cycle, so accesses run back-to-back.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_if  = 1'b0;
    case (state)
      IDLE: begin
        if (data_req && !(IF_Req && starve_cnt == SW'(STARVE_LIMIT))) begin
          grant_d   = 1'b1;
          state_nxt = D_BUSY;
        end else if (IF_Req) begin
          grant_if  = 1'b1;
          state_nxt = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, request capture, completion and starvation tracking.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      starve_cnt <= '0;
      Mem_Req    <= 1'b0;
      Mem_We     <= 1'b0;
      Mem_Addr   <= 32'd0;
      Mem_Wdata  <= 32'd0;
      IF_Ready   <= 1'b0;
      MEM_Ready  <= 1'b0;
      IF_Rdata   <= 32'd0;
      MEM_Rdata  <= 32'd0;
    end else begin
      state     <= state_nxt;
      IF_Ready  <= 1'b0;
      MEM_Ready <= 1'b0;

      if (grant_if) starve_cnt <= '0;
      else if (grant_d && IF_Req) starve_cnt <= starve_cnt + 1'b1;

      // Simultaneous read+write is treated as a write.
      if (grant_d) begin
        Mem_Req   <= 1'b1;
        Mem_We    <= MEM_Write;
        Mem_Addr  <= MEM_Addr;
        Mem_Wdata <= MEM_Wdata;
      end else if (grant_if) begin
        Mem_Req   <= 1'b1;
        Mem_We    <= 1'b0;
        Mem_Addr  <= IF_Addr;
        Mem_Wdata <= 32'd0;
      end

      // A write never returns data, so MEM_Rdata is left alone for it,
      // including on a watchdog abort.
      if (done) begin
        Mem_Req <= 1'b0;
        Mem_We  <= 1'b0;
        if (state == IF_BUSY) begin
          IF_Ready <= 1'b1;
          IF_Rdata <= timeout ? 32'd0 : Mem_Rdata;
        end else begin
          MEM_Ready <= 1'b1;
          if (!Mem_We) MEM_Rdata <= timeout ? 32'd0 : Mem_Rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants
// and responses; a memory responder and a ready monitor pop and compare.
module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IF_Req, MEM_Read, MEM_Write;
  logic [31:0] IF_Addr, MEM_Addr, MEM_Wdata;
  logic        IF_Ready, MEM_Ready, Stall_IF, Stall_MEM;
  logic [31:0] IF_Rdata, MEM_Rdata;
  logic        Mem_Req, Mem_We, Mem_Ack, Bus_Err;
  logic [31:0] Mem_Addr, Mem_Wdata, Mem_Rdata;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Ready(IF_Ready), .IF_Rdata(IF_Rdata),
    .MEM_Read(MEM_Read), .MEM_Write(MEM_Write), .MEM_Addr(MEM_Addr),
    .MEM_Wdata(MEM_Wdata), .MEM_Ready(MEM_Ready), .MEM_Rdata(MEM_Rdata),
    .Stall_IF(Stall_IF), .Stall_MEM(Stall_MEM),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Ack(Mem_Ack), .Mem_Rdata(Mem_Rdata), .Bus_Err(Bus_Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          len;   // expected Mem_Req-high cycles, 0 = don't care
  } grant_t;

  typedef struct {
    bit          is_if;
    logic [31:0] rdata;
  } rsp_t;

  grant_t grant_q[$];
  rsp_t   rsp_q[$];

  int checks = 0;
  int errors = 0;

  // responder controls
  bit ack_en    = 1'b1;
  int ack_delay = 1;
  bit force_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] resp(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2008_0005 : {a[15:0], 16'hC0DE};
  endfunction

  // Memory responder: checks each new access against the expected grant,
  // acks after ack_delay Mem_Req cycles, checks Mem_Req duration on drop.
  initial begin : responder
    bit     prev = 1'b0;
    int     cnt  = 0;
    grant_t g;
    g = '{32'd0, 1'b0, 32'd0, 0};
    Mem_Ack   = 1'b0;
    Mem_Rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge CLK);
      if (Mem_Req) begin
        if (!prev) begin
          cnt = 0;
          checks++;
          if (grant_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant: got addr %h expected none", Mem_Addr);
          end else begin
            g = grant_q.pop_front();
            chk("grant_addr", Mem_Addr, g.addr);
            chk("grant_we", {31'd0, Mem_We}, {31'd0, g.we});
            if (g.we) chk("grant_wdata", Mem_Wdata, g.wdata);
          end
        end
        cnt++;
        if (ack_en && cnt == ack_delay) begin
          Mem_Ack   = 1'b1;
          Mem_Rdata = resp(Mem_Addr);
        end else begin
          Mem_Ack   = 1'b0;
          Mem_Rdata = 32'hBAD0_BAD0;
        end
      end else begin
        if (prev && g.len != 0) chk("mem_req_cycles", cnt, g.len);
        Mem_Ack   = force_ack;
        Mem_Rdata = force_ack ? 32'h5555_AAAA : 32'hBAD0_BAD0;
      end
      prev = Mem_Req;
    end
  end

  // Ready monitor: every Ready pulse must match the oldest expected response.
  initial begin : monitor
    rsp_t r;
    forever begin
      @(negedge CLK);
      if (IF_Ready || MEM_Ready) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got if=%0b mem=%0b expected none", IF_Ready, MEM_Ready);
        end else begin
          r = rsp_q.pop_front();
          chk("ready_port_is_if", {31'd0, IF_Ready}, {31'd0, r.is_if});
          chk("ready_rdata", r.is_if ? IF_Rdata : MEM_Rdata, r.rdata);
        end
      end
    end
  end

  // which: 0 = data, 1 = IF, 2 = either. Leaves time at posedge+1 of the Ready cycle.
  task automatic wait_ready(input int which, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK); #1;
      if ((which == 0 && MEM_Ready) || (which == 1 && IF_Ready) ||
          (which == 2 && (IF_Ready || MEM_Ready))) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got no ready within 60 cycles expected ready", name);
    end
  endtask

  task automatic push_g(input logic [31:0] a, input logic we, input logic [31:0] wd, input int len);
    grant_t g;
    g.addr = a; g.we = we; g.wdata = wd; g.len = len;
    grant_q.push_back(g);
  endtask

  task automatic push_r(input bit is_if, input logic [31:0] d);
    rsp_t r;
    r.is_if = is_if; r.rdata = d;
    rsp_q.push_back(r);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin @(posedge CLK); #1; end
  endtask

  initial begin : stim
    bit ok;
    int n;
    RESET = 1'b1; IF_Req = 1'b0; MEM_Read = 1'b0; MEM_Write = 1'b0;
    IF_Addr = 32'd0; MEM_Addr = 32'd0; MEM_Wdata = 32'd0;
    tick(3);
    // reset state
    chk("rst_mem_req", {31'd0, Mem_Req}, 32'd0);
    chk("rst_mem_we", {31'd0, Mem_We}, 32'd0);
    chk("rst_mem_addr", Mem_Addr, 32'd0);
    chk("rst_mem_wdata", Mem_Wdata, 32'd0);
    chk("rst_readies", {30'd0, IF_Ready, MEM_Ready}, 32'd0);
    chk("rst_if_rdata", IF_Rdata, 32'd0);
    chk("rst_mem_rdata", MEM_Rdata, 32'd0);
    chk("rst_bus_err", {31'd0, Bus_Err}, 32'd0);
    RESET = 1'b0;
    tick(1);

    // 1: single fetch, ack in the first Mem_Req cycle
    ack_delay = 1;
    push_g(32'h40, 1'b0, 32'd0, 1);
    push_r(1'b1, 32'h2008_0005);
    IF_Req = 1'b1; IF_Addr = 32'h40;
    tick(1);
    chk("fetch_mem_req_rise", {31'd0, Mem_Req}, 32'd1);
    chk("fetch_stall_if_busy", {31'd0, Stall_IF}, 32'd1);
    wait_ready(1, "fetch_ready", ok);
    chk("fetch_stall_if_ready", {31'd0, Stall_IF}, 32'd0);
    IF_Req = 1'b0;
    tick(2);

    // 2: write and fetch together; data first, IF back-to-back
    push_g(32'h100, 1'b1, 32'hDEAD_BEEF, 1);
    push_r(1'b0, 32'd0);
    push_g(32'h44, 1'b0, 32'd0, 1);
    push_r(1'b1, 32'h0044_C0DE);
    IF_Req = 1'b1; IF_Addr = 32'h44;
    MEM_Write = 1'b1; MEM_Addr = 32'h100; MEM_Wdata = 32'hDEAD_BEEF;
    wait_ready(0, "write_ready", ok);
    chk("write_stall_mem_ready", {31'd0, Stall_MEM}, 32'd0);
    MEM_Write = 1'b0;
    tick(1);
    chk("b2b_mem_req", {31'd0, Mem_Req}, 32'd1);
    chk("b2b_mem_addr", Mem_Addr, 32'h44);
    wait_ready(1, "b2b_fetch_ready", ok);
    IF_Req = 1'b0;
    tick(2);

    // 3: starvation, both held for 6 accesses: D,D,D,D,IF,D
    ack_delay = 2;
    for (int i = 0; i < 4; i++) begin
      push_g(32'h200, 1'b0, 32'd0, 2);
      push_r(1'b0, 32'h0200_C0DE);
    end
    push_g(32'h80, 1'b0, 32'd0, 2);
    push_r(1'b1, 32'h0080_C0DE);
    push_g(32'h200, 1'b0, 32'd0, 2);
    push_r(1'b0, 32'h0200_C0DE);
    IF_Req = 1'b1; IF_Addr = 32'h80;
    MEM_Read = 1'b1; MEM_Addr = 32'h200;
    n = 0;
    while (n < 6) begin
      wait_ready(2, "starve_ready", ok);
      if (!ok) break;
      n++;
    end
    IF_Req = 1'b0; MEM_Read = 1'b0;
    tick(2);

    // 4: reset in the 2nd D_BUSY cycle, stray ack afterwards
    ack_en = 1'b0;
    push_g(32'h300, 1'b0, 32'd0, 2);
    MEM_Read = 1'b1; MEM_Addr = 32'h300;
    n = 0;
    while (!Mem_Req && n < 20) begin tick(1); n++; end
    tick(1);
    RESET = 1'b1; MEM_Read = 1'b0;
    tick(1);
    RESET = 1'b0; force_ack = 1'b1;
    chk("abort_mem_req", {31'd0, Mem_Req}, 32'd0);
    chk("abort_no_ready", {31'd0, MEM_Ready}, 32'd0);
    tick(1);
    force_ack = 1'b0;
    chk("idle_ack_mem_req", {31'd0, Mem_Req}, 32'd0);
    chk("idle_ack_no_ready", {31'd0, MEM_Ready}, 32'd0);
    chk("idle_ack_rdata", MEM_Rdata, 32'd0);
    tick(1);

    // 5: requester address/data change while busy must not leak
    ack_en = 1'b1; ack_delay = 3;
    push_g(32'h500, 1'b0, 32'd0, 3);
    push_r(1'b0, 32'h0500_C0DE);
    MEM_Read = 1'b1; MEM_Addr = 32'h500; MEM_Wdata = 32'h0;
    tick(1);
    MEM_Addr = 32'h9990; MEM_Wdata = 32'hFFFF_0000;
    tick(1);
    chk("busy_addr_stable", Mem_Addr, 32'h500);
    wait_ready(0, "read_ready", ok);
    MEM_Read = 1'b0;
    tick(2);

    // 6: read and write together behave as a write; MEM_Rdata held
    ack_delay = 1;
    push_g(32'h600, 1'b1, 32'h1234_5678, 1);
    push_r(1'b0, 32'h0500_C0DE);
    MEM_Read = 1'b1; MEM_Write = 1'b1; MEM_Addr = 32'h600; MEM_Wdata = 32'h1234_5678;
    wait_ready(0, "rw_ready", ok);
    MEM_Read = 1'b0; MEM_Write = 1'b0;
    tick(2);

    // 7: read that never gets an ack
    ack_en = 1'b0;
`ifdef ARB_TIMEOUT_EN
    push_g(32'h400, 1'b0, 32'd0, 8);
    push_r(1'b0, 32'd0);
    MEM_Read = 1'b1; MEM_Addr = 32'h400;
    wait_ready(0, "timeout_ready", ok);
    MEM_Read = 1'b0;
    tick(1);
    chk("timeout_bus_err", {31'd0, Bus_Err}, 32'd1);
    chk("timeout_mem_req", {31'd0, Mem_Req}, 32'd0);
    tick(5);
    chk("bus_err_sticky", {31'd0, Bus_Err}, 32'd1);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    chk("bus_err_cleared", {31'd0, Bus_Err}, 32'd0);
`else
    push_g(32'h400, 1'b0, 32'd0, 0);
    MEM_Read = 1'b1; MEM_Addr = 32'h400;
    tick(1);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("no_timeout_stall_mem", {31'd0, Stall_MEM}, 32'd1);
    end
    chk("no_timeout_bus_err", {31'd0, Bus_Err}, 32'd0);
    chk("no_timeout_mem_req", {31'd0, Mem_Req}, 32'd1);
    RESET = 1'b1; MEM_Read = 1'b0;
    tick(1);
    RESET = 1'b0;
`endif
    tick(3);
    chk("grant_q_drained", grant_q.size(), 32'd0);
    chk("rsp_q_drained", rsp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
